// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch lap core.
// Time is kept as packed binary fields {min, sec, ms_10}.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StPaused = 2'd2
   } state_e;

   typedef struct packed {
      logic [5:0] min;
      logic [5:0] sec;
      logic [6:0] ms_10;
   } time_t;

   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned MS10_MAX = 99;

endpackage

// File: rtl/stopwatch_lap_buf.sv
// Circular lap buffer: LAP_DEPTH time entries, saturating count, registered read port
// that starts at the oldest stored lap and steps towards the newest.
module stopwatch_lap_buf
   import stopwatch_pkg::*;
#(
   parameter int unsigned LAP_DEPTH = 8,
   localparam int unsigned AW = $clog2(LAP_DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          write_i,
   input  time_t         wdata_i,
   input  logic          start_i,
   input  logic          step_i,
   input  logic          clear_i,
   output time_t         rdata_o,
   output logic [CW-1:0] count_o
);

   time_t         mem_q [LAP_DEPTH];
   time_t         rdata_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full;
   logic [AW-1:0] oldest;

   assign full   = (count_q == CW'(LAP_DEPTH));
   // Once the buffer has wrapped, the next slot to be written holds the oldest lap.
   assign oldest = full ? wr_ptr_q : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q    <= '{default: '0};
         rdata_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         mem_q    <= '{default: '0};
         rdata_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (write_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
            if (!full) begin
               count_q <= count_q + 1'b1;
            end
         end
         if (start_i) begin
            rdata_q  <= mem_q[oldest];
            rd_ptr_q <= oldest + 1'b1;
         end else if (step_i) begin
            rdata_q  <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign rdata_o = rdata_q;
   assign count_o = count_q;

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: tick prescaler, min/sec/10ms counter, run/pause FSM and lap recall.
// Optional countdown mode is enabled with the STOPWATCH_COUNTDOWN_EN macro.
module stopwatch_lap_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned TICK_HZ   = 100,
   parameter int unsigned LAP_DEPTH = 8,
   parameter int unsigned MIN_MAX   = 59,
   localparam int unsigned CW = $clog2(LAP_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pause,
   input  logic          record,
`ifdef STOPWATCH_COUNTDOWN_EN
   input  logic          mode_i,
   input  logic          load,
   input  logic [5:0]    min_set,
   input  logic [5:0]    sec_set,
   output logic          done_o,
`endif
   output logic [5:0]    min_o,
   output logic [5:0]    sec_o,
   output logic [6:0]    ms_10_o,
   output logic          running_o,
   output logic          recall_o,
   output logic [CW-1:0] lap_cnt_o,
   output logic          ovf_o
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned PW  = $clog2(DIV);
   localparam logic [PW-1:0] PrescLast = PW'(DIV - 1);

   state_e        state_q, state_d;
   time_t         time_q, time_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          ovf_q, ovf_d;
   logic          recall_q, recall_d;
   logic [CW-1:0] shown_q, shown_d;
   logic          tick;
   logic          lap_wr, lap_start, lap_step, lap_clr;
   time_t         lap_rdata;
   logic [CW-1:0] lap_cnt;
   time_t         disp;
`ifdef STOPWATCH_COUNTDOWN_EN
   logic          mode_q, mode_d;
   logic          done_q, done_d;
`endif

   always_comb begin
      state_d   = state_q;
      time_d    = time_q;
      presc_d   = presc_q;
      ovf_d     = ovf_q;
      recall_d  = recall_q;
      shown_d   = shown_q;
      lap_wr    = 1'b0;
      lap_start = 1'b0;
      lap_step  = 1'b0;
      lap_clr   = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
      mode_d    = mode_q;
      done_d    = 1'b0;
`endif
      tick = (state_q == StRun) && (presc_q == PrescLast);
      if (state_q == StRun) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      if (tick) begin
`ifdef STOPWATCH_COUNTDOWN_EN
         if (mode_q) begin
            if (time_q.ms_10 != '0) begin
               time_d.ms_10 = time_q.ms_10 - 1'b1;
            end else if (time_q.sec != '0) begin
               time_d.ms_10 = 7'(MS10_MAX);
               time_d.sec   = time_q.sec - 1'b1;
            end else if (time_q.min != '0) begin
               time_d.ms_10 = 7'(MS10_MAX);
               time_d.sec   = 6'(SEC_MAX);
               time_d.min   = time_q.min - 1'b1;
            end
            // Reaching zero stops the count instead of wrapping.
            if (time_d == '0) begin
               state_d = StPaused;
               done_d  = 1'b1;
            end
         end else begin
`else
         begin
`endif
            if (time_q.ms_10 != 7'(MS10_MAX)) begin
               time_d.ms_10 = time_q.ms_10 + 1'b1;
            end else begin
               time_d.ms_10 = '0;
               if (time_q.sec != 6'(SEC_MAX)) begin
                  time_d.sec = time_q.sec + 1'b1;
               end else begin
                  time_d.sec = '0;
                  if (time_q.min != 6'(MIN_MAX)) begin
                     time_d.min = time_q.min + 1'b1;
                  end else begin
                     time_d.min = '0;
                     ovf_d      = 1'b1;
                  end
               end
            end
         end
      end

      unique case (state_q)
         StIdle: begin
            presc_d = '0;
`ifdef STOPWATCH_COUNTDOWN_EN
            mode_d = mode_i;
            if (load) begin
               time_d = '{min: min_set, sec: sec_set, ms_10: '0};
            end
`endif
            if (pause) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (pause) begin
               state_d = StPaused;
            end else if (record) begin
               lap_wr = 1'b1;
            end
         end
         StPaused: begin
            if (pause && record) begin
               state_d  = StIdle;
               time_d   = '0;
               presc_d  = '0;
               ovf_d    = 1'b0;
               recall_d = 1'b0;
               shown_d  = '0;
               lap_clr  = 1'b1;
            end else if (pause) begin
               state_d  = StRun;
               recall_d = 1'b0;
            end else if (record && (lap_cnt != '0)) begin
               if (!recall_q) begin
                  recall_d  = 1'b1;
                  lap_start = 1'b1;
                  shown_d   = CW'(1);
               end else if (shown_q == lap_cnt) begin
                  recall_d = 1'b0;
               end else begin
                  lap_step = 1'b1;
                  shown_d  = shown_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         time_q   <= '0;
         presc_q  <= '0;
         ovf_q    <= 1'b0;
         recall_q <= 1'b0;
         shown_q  <= '0;
`ifdef STOPWATCH_COUNTDOWN_EN
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         time_q   <= time_d;
         presc_q  <= presc_d;
         ovf_q    <= ovf_d;
         recall_q <= recall_d;
         shown_q  <= shown_d;
`ifdef STOPWATCH_COUNTDOWN_EN
         mode_q   <= mode_d;
         done_q   <= done_d;
`endif
      end
   end

   stopwatch_lap_buf #(
      .LAP_DEPTH(LAP_DEPTH)
   ) u_lap_buf (
      .clk    (clk),
      .rst    (rst),
      .write_i(lap_wr),
      .wdata_i(time_q),
      .start_i(lap_start),
      .step_i (lap_step),
      .clear_i(lap_clr),
      .rdata_o(lap_rdata),
      .count_o(lap_cnt)
   );

   assign disp      = recall_q ? lap_rdata : time_q;
   assign min_o     = disp.min;
   assign sec_o     = disp.sec;
   assign ms_10_o   = disp.ms_10;
   assign running_o = (state_q == StRun);
   assign recall_o  = recall_q;
   assign lap_cnt_o = lap_cnt;
   assign ovf_o     = ovf_q;
`ifdef STOPWATCH_COUNTDOWN_EN
   assign done_o    = done_q;
`endif

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench: dut A (DIV=10, 4 laps) for counting, laps, recall and pause fraction;
// dut B (DIV=2, MIN_MAX=1) for wrap, overflow and the clear gesture.
module tb_stopwatch_lap_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_pause, a_record, b_pause, b_record;
   logic [5:0] a_min, a_sec, b_min, b_sec;
   logic [6:0] a_ms, b_ms;
   logic       a_run, a_rec, a_ovf, b_run, b_rec, b_ovf;
   logic [2:0] a_cnt;
   logic [1:0] b_cnt;
`ifdef STOPWATCH_COUNTDOWN_EN
   logic       a_done, b_done;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   stopwatch_lap_core #(
      .CLK_HZ   (1000),
      .TICK_HZ  (100),
      .LAP_DEPTH(4),
      .MIN_MAX  (59)
   ) u_dut_a (
      .clk      (clk),
      .rst      (rst),
      .pause    (a_pause),
      .record   (a_record),
`ifdef STOPWATCH_COUNTDOWN_EN
      .mode_i   (1'b0),
      .load     (1'b0),
      .min_set  (6'd0),
      .sec_set  (6'd0),
      .done_o   (a_done),
`endif
      .min_o    (a_min),
      .sec_o    (a_sec),
      .ms_10_o  (a_ms),
      .running_o(a_run),
      .recall_o (a_rec),
      .lap_cnt_o(a_cnt),
      .ovf_o    (a_ovf)
   );

   stopwatch_lap_core #(
      .CLK_HZ   (200),
      .TICK_HZ  (100),
      .LAP_DEPTH(2),
      .MIN_MAX  (1)
   ) u_dut_b (
      .clk      (clk),
      .rst      (rst),
      .pause    (b_pause),
      .record   (b_record),
`ifdef STOPWATCH_COUNTDOWN_EN
      .mode_i   (1'b0),
      .load     (1'b0),
      .min_set  (6'd0),
      .sec_set  (6'd0),
      .done_o   (b_done),
`endif
      .min_o    (b_min),
      .sec_o    (b_sec),
      .ms_10_o  (b_ms),
      .running_o(b_run),
      .recall_o (b_rec),
      .lap_cnt_o(b_cnt),
      .ovf_o    (b_ovf)
   );

   typedef struct {
      int    p;
      int    r;
      int    n;
      int    mn;
      int    sc;
      int    ms;
      int    run;
      int    rec;
      int    cnt;
      string nm;
   } vec_t;

   vec_t vecs[21];

   function automatic logic [31:0] pk(int mn, int sc, int ms, int run, int rec, int cnt, int ovf);
      pk = {6'd0, 6'(mn), 6'(sc), 7'(ms), 1'(run), 1'(rec), 4'(cnt), 1'(ovf)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h (min,sec,ms,run,rec,cnt,ovf packed) expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_a(input int p, input int r);
      a_pause  = 1'(p);
      a_record = 1'(r);
      cyc(1);
      a_pause  = 1'b0;
      a_record = 1'b0;
   endtask

   task automatic pulse_b(input int p, input int r);
      b_pause  = 1'(p);
      b_record = 1'(r);
      cyc(1);
      b_pause  = 1'b0;
      b_record = 1'b0;
   endtask

   function automatic logic [31:0] act_a();
      act_a = pk(a_min, a_sec, a_ms, a_run, a_rec, a_cnt, a_ovf);
   endfunction

   function automatic logic [31:0] act_b();
      act_b = pk(b_min, b_sec, b_ms, b_run, b_rec, b_cnt, b_ovf);
   endfunction

   initial begin
      // Laps land at 100, 109, 124, 129 (tick cycle), 130, 180 hundredths; 3..6 survive.
      vecs[0]  = '{0, 1,   0, 0, 0,  0, 0, 0, 0, "idle_record"};
      vecs[1]  = '{1, 0,   9, 0, 0,  0, 1, 0, 0, "start"};
      vecs[2]  = '{0, 0,   0, 0, 0,  1, 1, 0, 0, "first_tick"};
      vecs[3]  = '{0, 0, 989, 0, 1,  0, 1, 0, 0, "one_sec"};
      vecs[4]  = '{0, 1,  95, 0, 1,  9, 1, 0, 1, "lap1"};
      vecs[5]  = '{0, 1, 150, 0, 1, 24, 1, 0, 2, "lap2"};
      vecs[6]  = '{0, 1,  51, 0, 1, 29, 1, 0, 3, "lap3"};
      vecs[7]  = '{0, 1,   0, 0, 1, 30, 1, 0, 4, "lap4_on_tick"};
      vecs[8]  = '{0, 1, 500, 0, 1, 80, 1, 0, 4, "lap5"};
      vecs[9]  = '{0, 1,   3, 0, 1, 80, 1, 0, 4, "lap6"};
      vecs[10] = '{1, 0,  50, 0, 1, 80, 0, 0, 4, "pause"};
      vecs[11] = '{0, 1,   0, 0, 1, 24, 0, 1, 4, "recall_lap3"};
      vecs[12] = '{0, 1,   0, 0, 1, 29, 0, 1, 4, "recall_lap4"};
      vecs[13] = '{0, 1,   0, 0, 1, 30, 0, 1, 4, "recall_lap5"};
      vecs[14] = '{0, 1,   0, 0, 1, 80, 0, 1, 4, "recall_lap6"};
      vecs[15] = '{0, 1,   0, 0, 1, 80, 0, 0, 4, "recall_live"};
      vecs[16] = '{0, 1,   0, 0, 1, 24, 0, 1, 4, "recall_again"};
      vecs[17] = '{1, 0,   3, 0, 1, 80, 1, 0, 4, "resume_from_recall"};
      vecs[18] = '{0, 0,   0, 0, 1, 81, 1, 0, 4, "kept_fraction"};
      vecs[19] = '{1, 0,   0, 0, 1, 81, 0, 0, 4, "pause2"};
      vecs[20] = '{0, 1,   0, 0, 1, 24, 0, 1, 4, "recall_before_rst"};

      rst      = 1'b0;
      a_pause  = 1'b0;
      a_record = 1'b0;
      b_pause  = 1'b0;
      b_record = 1'b0;
      cyc(3);
      chk("reset_a", act_a(), pk(0, 0, 0, 0, 0, 0, 0));
      chk("reset_b", act_b(), pk(0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      cyc(1);

      for (int i = 0; i < 21; i++) begin
         pulse_a(vecs[i].p, vecs[i].r);
         cyc(vecs[i].n);
         chk(vecs[i].nm, act_a(),
             pk(vecs[i].mn, vecs[i].sc, vecs[i].ms, vecs[i].run, vecs[i].rec, vecs[i].cnt, 0));
      end

      // Asynchronous reset while a lap is on display.
      #2 rst = 1'b0;
      #1 chk("rst_in_recall", act_a(), pk(0, 0, 0, 0, 0, 0, 0));
      cyc(2);
      rst = 1'b1;
      cyc(1);

      // Pause after 5 prescaler cycles; the remaining 5 follow the resume.
      pulse_a(1, 0);
      cyc(4);
      pulse_a(1, 0);
      chk("frac_paused", act_a(), pk(0, 0, 0, 0, 0, 0, 0));
      cyc(50);
      chk("frac_hold", act_a(), pk(0, 0, 0, 0, 0, 0, 0));
      pulse_a(1, 0);
      cyc(4);
      chk("frac_before", act_a(), pk(0, 0, 0, 1, 0, 0, 0));
      cyc(1);
      chk("frac_fifth", act_a(), pk(0, 0, 1, 1, 0, 0, 0));

      #3 rst = 1'b0;
      #1 chk("rst_mid_run", act_a(), pk(0, 0, 0, 0, 0, 0, 0));
      cyc(2);
      rst = 1'b1;
      cyc(1);

      // dut B: tick every second run cycle, wraps after 1:59:99.
      pulse_b(1, 0);
      pulse_b(1, 1);
      chk("b_pair_in_run", act_b(), pk(0, 0, 0, 0, 0, 0, 0));
      pulse_b(0, 1);
      chk("b_recall_empty", act_b(), pk(0, 0, 0, 0, 0, 0, 0));
      pulse_b(1, 0);
      cyc(23997);
      chk("b_max_time", act_b(), pk(1, 59, 99, 1, 0, 0, 0));
      pulse_b(0, 1);
      chk("b_lap", act_b(), pk(1, 59, 99, 1, 0, 1, 0));
      cyc(1);
      chk("b_wrap", act_b(), pk(0, 0, 0, 1, 0, 1, 1));
      pulse_b(1, 0);
      chk("b_paused_ovf", act_b(), pk(0, 0, 0, 0, 0, 1, 1));
      pulse_b(0, 1);
      chk("b_recall", act_b(), pk(1, 59, 99, 0, 1, 1, 1));
      pulse_b(1, 1);
      chk("b_clear", act_b(), pk(0, 0, 0, 0, 0, 0, 0));
      pulse_b(1, 0);
      cyc(1);
      chk("b_restart", act_b(), pk(0, 0, 0, 1, 0, 0, 0));
      cyc(1);
      chk("b_first_tick", act_b(), pk(0, 0, 1, 1, 0, 0, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
